data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store port. Accepts one request at a time

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, fixed wait states, then a held response.
// Owns a word-organised data array with byte-lane writes and RV32-style extended loads.
//
// state  | meaning
// S_IDLE | ready for a request; fields captured on accept
// S_WAIT | counting down wait states
// S_RESP | response presented until resp_ready
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_acc_type,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept, enter_resp;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [2:0]  cap_acc;

    logic        eff_we;
    logic [31:0] eff_addr, eff_wdata;
    logic [2:0]  eff_acc;
    logic        err_comb;
    logic [3:0]  be;
    logic [31:0] wword;
    logic [ADDR_WIDTH-1:0] word_idx;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [31:0] rd_word_q;
    logic [31:0] shifted, ext_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_acc   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_we    <= req_we;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_acc   <= req_acc_type;
            end
        end
    end

    // With zero wait states the array access happens on the accept edge, so use live inputs in IDLE.
    assign eff_we    = (state_q == S_IDLE) ? req_we       : cap_we;
    assign eff_addr  = (state_q == S_IDLE) ? req_addr     : cap_addr;
    assign eff_wdata = (state_q == S_IDLE) ? req_wdata    : cap_wdata;
    assign eff_acc   = (state_q == S_IDLE) ? req_acc_type : cap_acc;
    assign word_idx  = eff_addr[ADDR_WIDTH+1:2];

    always_comb begin
        err_comb = ((eff_addr >> (ADDR_WIDTH + 2)) != 32'd0) || (eff_we && eff_acc[2]);
        case (eff_acc)
            3'b000, 3'b100: ;
            3'b001, 3'b101: if (eff_addr[0]) err_comb = 1'b1;
            3'b010:         if (eff_addr[1:0] != 2'b00) err_comb = 1'b1;
            default:        err_comb = 1'b1;
        endcase
    end

    always_comb begin
        case (eff_acc[1:0])
            2'b00: begin
                be    = 4'b0001 << eff_addr[1:0];
                wword = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                be    = eff_addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{eff_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = eff_wdata;
            end
        endcase
    end

    // Array is not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && enter_resp) begin
            if (eff_we && !err_comb) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
            if (!eff_we) rd_word_q <= mem[word_idx];
        end
    end

    assign shifted = rd_word_q >> {cap_addr[1:0], 3'b000};

    always_comb begin
        case (cap_acc)
            3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext_data = {24'd0, shifted[7:0]};
            3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext_data = {16'd0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_comb;
    assign resp_rdata = (state_q == S_RESP && !cap_we && !err_comb) ? ext_data : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_acc_type;
    int          sel;
    int          total = 0;
    int          bad   = 0;

    logic [1:0]  rv, rr, req_ready_w, resp_valid_w, resp_err_w;
    logic [31:0] rdata0, rdata1;
    logic        cur_req_ready, cur_resp_valid, cur_resp_err;
    logic [31:0] cur_rdata;

    always #5 clk = ~clk;

    assign rv[0] = req_valid  && (sel == 0);
    assign rv[1] = req_valid  && (sel == 1);
    assign rr[0] = resp_ready && (sel == 0);
    assign rr[1] = resp_ready && (sel == 1);

    assign cur_req_ready  = req_ready_w[sel[0]];
    assign cur_resp_valid = resp_valid_w[sel[0]];
    assign cur_resp_err   = resp_err_w[sel[0]];
    assign cur_rdata      = sel[0] ? rdata1 : rdata0;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(req_ready_w[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_acc_type(req_acc_type), .resp_valid(resp_valid_w[0]), .resp_ready(rr[0]),
        .resp_rdata(rdata0), .resp_err(resp_err_w[0])
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(req_ready_w[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_acc_type(req_acc_type), .resp_valid(resp_valid_w[1]), .resp_ready(rr[1]),
        .resp_rdata(rdata1), .resp_err(resp_err_w[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},  32'(cur_req_ready),  32'd1);
        check({tag, " resp_valid"}, 32'(cur_resp_valid), 32'd0);
        check({tag, " resp_rdata"}, cur_rdata,           32'd0);
        check({tag, " resp_err"},   32'(cur_resp_err),   32'd0);
    endtask

    // One full transaction; hold>0 keeps resp_ready low that many cycles in RESP.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] acc,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int edges;
        int wait_cur;
        wait_cur = (sel == 0) ? 2 : 0;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_acc_type = acc;
        req_valid = 1'b1;
        resp_ready = (hold == 0);
        check({tag, " ready"}, 32'(cur_req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        edges = 1;
        while (!cur_resp_valid && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, 32'(edges), 32'(wait_cur + 1));
        check({tag, " rdata"}, cur_rdata, exp_rdata);
        check({tag, " err"}, 32'(cur_resp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = (i == 1);
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(cur_resp_valid), 32'd1);
            check({tag, " hold rdata"}, cur_rdata, exp_rdata);
            check({tag, " hold err"}, 32'(cur_resp_err), 32'(exp_err));
            check({tag, " hold req_ready"}, 32'(cur_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " done valid"}, 32'(cur_resp_valid), 32'd0);
        check({tag, " done ready"}, 32'(cur_req_ready), 32'd1);
        if (hold > 0) begin
            @(posedge clk); #1;
            check({tag, " no stray accept"}, 32'(cur_resp_valid), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_acc_type = 3'd0;
        sel = 0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check_reset_outputs("reset");
            @(negedge clk);
            rst = 1'b1;

            do_req("sw 10",  1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0, 0);
            do_req("lw 10",  1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 0);
            do_req("sb 12",  1'b1, 32'h12, 32'h00000080, 3'b000, 32'h0,        1'b0, 0);
            do_req("lb 12",  1'b0, 32'h12, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 0);
            do_req("lbu 12", 1'b0, 32'h12, 32'h0,        3'b100, 32'h00000080, 1'b0, 0);
            do_req("lw 10b", 1'b0, 32'h10, 32'h0,        3'b010, 32'hDE80BEEF, 1'b0, 0);
            do_req("sh 22",  1'b1, 32'h22, 32'h00008001, 3'b001, 32'h0,        1'b0, 0);
            do_req("lh 22",  1'b0, 32'h22, 32'h0,        3'b001, 32'hFFFF8001, 1'b0, 0);
            do_req("lhu 22", 1'b0, 32'h22, 32'h0,        3'b101, 32'h00008001, 1'b0, 0);
            do_req("lh 21",  1'b0, 32'h21, 32'h0,        3'b001, 32'h0,        1'b1, 0);
            do_req("sw 13",  1'b1, 32'h13, 32'h12345678, 3'b010, 32'h0,        1'b1, 0);
            do_req("lw 10c", 1'b0, 32'h10, 32'h0,        3'b010, 32'hDE80BEEF, 1'b0, 0);
            do_req("lw oor", 1'b0, 32'h1000, 32'h0,      3'b010, 32'h0,        1'b1, 0);
            do_req("acc 011", 1'b0, 32'h10, 32'h0,       3'b011, 32'h0,        1'b1, 0);
            do_req("sbu",    1'b1, 32'h14, 32'h55,       3'b100, 32'h0,        1'b1, 0);
            do_req("stall",  1'b0, 32'h10, 32'h0,        3'b010, 32'hDE80BEEF, 1'b0, 5);
            do_req("sw 30",  1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 0);

            // Reset mid-transaction: in WAIT for the two-wait instance, in RESP for the zero-wait one.
            @(negedge clk);
            req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h1; req_acc_type = 3'b010;
            req_valid = 1'b1; resp_ready = 1'b0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("midrst busy", 32'(cur_req_ready), 32'd0);
            #1 rst = 1'b0;
            #1;
            check_reset_outputs("midrst");
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            do_req("lw 30", 1'b0, 32'h30, 32'h0, 3'b010,
                   (s == 0) ? 32'hCAFEF00D : 32'h00000001, 1'b0, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
